// File: rtl/hpm_window_tracer.sv
// HPM window tracer: periodic counter snapshots between CSR open/close, streamed out via a FIFO.
// Ports: clk_h/rst_h, csr_*_i window control, period_i, hpm_i, snap_* stream, drop_cnt_o, enable_detect_o/end_detect_i, state_o.
// Optional: define HPM_DELTA_EN to export per-window counter deltas instead of absolute values.
module hpm_window_tracer #(
  parameter int          N_CNT    = 12,
  parameter int          CNT_W    = 64,
  parameter int          DEPTH    = 8,
  parameter logic [11:0] CSR_ADDR = 12'h320,
  parameter int          PER_W    = 16
) (
  input  logic                   clk_h,
  input  logic                   rst_h,
  input  logic                   csr_we_i,
  input  logic [11:0]            csr_add_i,
  input  logic [31:0]            csr_data_i,
  input  logic [PER_W-1:0]       period_i,
  input  logic [N_CNT*CNT_W-1:0] hpm_i,
  output logic                   snap_valid_o,
  input  logic                   snap_ready_i,
  output logic [N_CNT*CNT_W-1:0] snap_data_o,
  output logic [15:0]            snap_seq_o,
  output logic                   snap_last_o,
  output logic [15:0]            drop_cnt_o,
  output logic                   enable_detect_o,
  input  logic                   end_detect_i,
  output logic [1:0]             state_o
);

  localparam int DW = N_CNT * CNT_W;
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MON   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [PER_W-1:0] timer_q, timer_d;
  logic [AW:0]      wr_q, rd_q;
  logic [15:0]      seq_q;
  logic [15:0]      drop_q;

  logic [DW-1:0]    mem_data [DEPTH];
  logic [15:0]      mem_seq  [DEPTH];
  logic [DEPTH-1:0] mem_last;

  logic          open_w, close_w, tick;
  logic          empty, full, pop;
  logic          push_req, push_last, push_ok, drop;
  logic          drop_clr, base_ld;
  logic [DW-1:0] payload;

  assign open_w  = csr_we_i && (csr_add_i == CSR_ADDR)
                && (csr_data_i == 32'h0000_0000);
  assign close_w = csr_we_i && (csr_add_i == CSR_ADDR)
                && (csr_data_i == 32'hFFFF_FFFF);

  // >= rather than == so a period shrunk below the
  // running timer still fires at the next compare.
  assign tick = (period_i != '0)
             && (timer_q >= period_i - PER_W'(1));

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW])
              && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop   = !empty && snap_ready_i;

  // A full FIFO still accepts a push when it pops
  // in the same cycle.
  assign push_ok = push_req && (!full || pop);
  assign drop    = push_req && full && !pop;

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    push_req  = 1'b0;
    push_last = 1'b0;
    drop_clr  = 1'b0;
    base_ld   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (open_w) begin
          state_d  = MON;
          timer_d  = '0;
          drop_clr = 1'b1;
          base_ld  = 1'b1;
        end
      end
      MON: begin
        if (close_w) begin
          push_req  = 1'b1;
          push_last = 1'b1;
          timer_d   = '0;
          state_d   = DRAIN;
        end else begin
          if (period_i == '0) begin
            timer_d = '0;
          end else if (tick) begin
            push_req = 1'b1;
            timer_d  = '0;
          end else begin
            timer_d = timer_q + PER_W'(1);
          end
          if (open_w) begin
            timer_d = '0;
          end
        end
      end
      DRAIN: begin
        if (empty && end_detect_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

`ifdef HPM_DELTA_EN
  logic [DW-1:0] base_q;

  // Baseline follows every attempted push, so a
  // dropped snapshot does not inflate the next delta.
  always_ff @(posedge clk_h or negedge rst_h) begin
    if (!rst_h) begin
      base_q <= '0;
    end else if (base_ld || push_req) begin
      base_q <= hpm_i;
    end
  end

  for (genvar k = 0; k < N_CNT; k++) begin : g_delta
    assign payload[k*CNT_W +: CNT_W] =
      hpm_i[k*CNT_W +: CNT_W] - base_q[k*CNT_W +: CNT_W];
  end
`else
  logic unused_base;
  assign unused_base = base_ld;
  assign payload     = hpm_i;
`endif

  always_ff @(posedge clk_h or negedge rst_h) begin
    if (!rst_h) begin
      state_q <= IDLE;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  always_ff @(posedge clk_h or negedge rst_h) begin
    if (!rst_h) begin
      wr_q     <= '0;
      rd_q     <= '0;
      seq_q    <= '0;
      mem_last <= '0;
    end else begin
      if (push_ok) begin
        wr_q                     <= wr_q + (AW+1)'(1);
        seq_q                    <= seq_q + 16'd1;
        mem_last[wr_q[AW-1:0]]   <= push_last;
      end
      if (pop) begin
        rd_q <= rd_q + (AW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk_h or negedge rst_h) begin
    if (!rst_h) begin
      drop_q <= '0;
    end else if (drop_clr) begin
      drop_q <= '0;
    end else if (drop && (drop_q != 16'hFFFF)) begin
      drop_q <= drop_q + 16'd1;
    end
  end

  // Payload storage carries no reset; the read side
  // is masked while the FIFO is empty.
  always_ff @(posedge clk_h) begin
    if (push_ok) begin
      mem_data[wr_q[AW-1:0]] <= payload;
      mem_seq[wr_q[AW-1:0]]  <= seq_q;
    end
  end

  assign snap_valid_o    = !empty;
  assign snap_data_o     = empty ? '0 : mem_data[rd_q[AW-1:0]];
  assign snap_seq_o      = empty ? '0 : mem_seq[rd_q[AW-1:0]];
  assign snap_last_o     = empty ? 1'b0 : mem_last[rd_q[AW-1:0]];
  assign drop_cnt_o      = drop_q;
  assign enable_detect_o = (state_q == DRAIN);
  assign state_o         = state_q;

endmodule

// File: tb/tb_hpm_window_tracer.sv
// Bench for hpm_window_tracer: directed windows, scoreboard queue
// filled by stimulus and drained by a monitor on the output stream.
module tb_hpm_window_tracer;

  localparam int N_CNT = 12;
  localparam int CNT_W = 64;
  localparam int DEPTH = 8;
  localparam int PER_W = 16;
  localparam int DW    = N_CNT * CNT_W;

  logic             clk_h = 1'b0;
  logic             rst_h = 1'b1;
  logic             csr_we_i = 1'b0;
  logic [11:0]      csr_add_i = '0;
  logic [31:0]      csr_data_i = '0;
  logic [PER_W-1:0] period_i = '0;
  logic [DW-1:0]    hpm_i;
  logic             snap_valid_o;
  logic             snap_ready_i = 1'b0;
  logic [DW-1:0]    snap_data_o;
  logic [15:0]      snap_seq_o;
  logic             snap_last_o;
  logic [15:0]      drop_cnt_o;
  logic             enable_detect_o;
  logic             end_detect_i = 1'b0;
  logic [1:0]       state_o;

  hpm_window_tracer #(
    .N_CNT(N_CNT), .CNT_W(CNT_W), .DEPTH(DEPTH),
    .CSR_ADDR(12'h320), .PER_W(PER_W)
  ) dut (
    .clk_h(clk_h), .rst_h(rst_h),
    .csr_we_i(csr_we_i), .csr_add_i(csr_add_i),
    .csr_data_i(csr_data_i), .period_i(period_i),
    .hpm_i(hpm_i), .snap_valid_o(snap_valid_o),
    .snap_ready_i(snap_ready_i), .snap_data_o(snap_data_o),
    .snap_seq_o(snap_seq_o), .snap_last_o(snap_last_o),
    .drop_cnt_o(drop_cnt_o), .enable_detect_o(enable_detect_o),
    .end_detect_i(end_detect_i), .state_o(state_o)
  );

  always #5 clk_h = ~clk_h;

  longint cyc = 0;
  always @(posedge clk_h) cyc <= cyc + 1;

  // Counter k reads cyc + 1000*k.
  always_comb begin
    hpm_i = '0;
    for (int k = 0; k < N_CNT; k++)
      hpm_i[k*CNT_W +: CNT_W] = 64'(cyc + longint'(k) * 1000);
  end

  typedef struct {
    logic [DW-1:0] data;
    logic [15:0]   seq;
    logic          last;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] mseq = '0;
  longint      prev = 0;
  longint      c0, c1;
  logic [15:0] s;

  function automatic logic [DW-1:0] mk(longint v);
    logic [DW-1:0] r;
    r = '0;
    for (int k = 0; k < N_CNT; k++) begin
`ifdef HPM_DELTA_EN
      r[k*CNT_W +: CNT_W] = 64'(v - prev);
`else
      r[k*CNT_W +: CNT_W] = 64'(v + longint'(k) * 1000);
`endif
    end
    return r;
  endfunction

  task automatic exp_push(longint v, logic l);
    exp_t e;
    e.data = mk(v);
    e.seq  = mseq;
    e.last = l;
    q.push_back(e);
    mseq = mseq + 16'd1;
    prev = v;
  endtask

  task automatic exp_drop(longint v);
    prev = v;
  endtask

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic step(int n);
    repeat (n) @(posedge clk_h);
    #1;
  endtask

  task automatic csr(logic [11:0] a, logic [31:0] d);
    csr_we_i   = 1'b1;
    csr_add_i  = a;
    csr_data_i = d;
    step(1);
    csr_we_i   = 1'b0;
  endtask

  always @(negedge clk_h) begin
    if (rst_h && snap_valid_o && snap_ready_i) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_snap seq=%0h", snap_seq_o);
      end else begin
        exp_t e;
        e = q.pop_front();
        checks++;
        if (snap_data_o !== e.data) begin
          errors++;
          $display("FAIL snap_data seq=%0h act=%h exp=%h",
                   e.seq, snap_data_o, e.data);
        end
        chk("snap_seq", 64'(snap_seq_o), 64'(e.seq));
        chk("snap_last", 64'(snap_last_o), 64'(e.last));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst_h = 1'b0;
    step(2);
    chk("rst_valid", 64'(snap_valid_o), 0);
    chk("rst_state", 64'(state_o), 0);
    chk("rst_drop", 64'(drop_cnt_o), 0);
    chk("rst_en", 64'(enable_detect_o), 0);
    chk("rst_seq", 64'(snap_seq_o), 0);
    chk("rst_last", 64'(snap_last_o), 0);
    chk("rst_data", 64'(snap_data_o[63:0]), 0);
    rst_h = 1'b1;
    step(1);

    // Window with period 4, close 18 cycles after open.
    period_i = 16'd4;
    snap_ready_i = 1'b1;
    c0 = cyc;
    prev = c0;
    for (int j = 1; j <= 4; j++) exp_push(c0 + 4*j, 1'b0);
    exp_push(c0 + 18, 1'b1);
    csr(12'h320, 32'h0);
    chk("t1_mon", 64'(state_o), 1);
    chk("t1_en_mon", 64'(enable_detect_o), 0);
    step(17);
    csr(12'h320, 32'hFFFF_FFFF);
    chk("t1_drain", 64'(state_o), 2);
    chk("t1_en", 64'(enable_detect_o), 1);
    step(3);
    chk("t1_hold", 64'(state_o), 2);
    chk("t1_qempty", 64'(q.size()), 0);
    end_detect_i = 1'b1;
    step(1);
    chk("t1_idle", 64'(state_o), 0);
    chk("t1_en_off", 64'(enable_detect_o), 0);
    end_detect_i = 1'b0;

    // Period 1 with a stalled consumer: fill, drop,
    // push+pop on full, then a dropped closing push.
    snap_ready_i = 1'b0;
    period_i = 16'd1;
    c0 = cyc;
    prev = c0;
    s = mseq;
    for (int j = 1; j <= 8; j++) exp_push(c0 + j, 1'b0);
    for (int j = 9; j <= 12; j++) exp_drop(c0 + j);
    exp_push(c0 + 13, 1'b0);
    exp_drop(c0 + 14);
    csr(12'h320, 32'h0);
    step(12);
    chk("t2_drop", 64'(drop_cnt_o), 4);
    chk("t2_head_seq", 64'(snap_seq_o), 64'(s));
    chk("t2_valid", 64'(snap_valid_o), 1);
    snap_ready_i = 1'b1;
    step(1);
    snap_ready_i = 1'b0;
    chk("t3_drop", 64'(drop_cnt_o), 4);
    chk("t3_head_seq", 64'(snap_seq_o), 64'(s + 16'd1));
    csr(12'h320, 32'hFFFF_FFFF);
    chk("t3_drop_last", 64'(drop_cnt_o), 5);
    chk("t3_drain", 64'(state_o), 2);
    snap_ready_i = 1'b1;
    step(10);
    chk("t3_empty", 64'(snap_valid_o), 0);
    chk("t3_qempty", 64'(q.size()), 0);
    end_detect_i = 1'b1;
    step(1);
    chk("t3_idle", 64'(state_o), 0);
    end_detect_i = 1'b0;

    // Period 0 and ignored CSR writes.
    period_i = 16'd0;
    csr(12'h320, 32'h5);
    chk("t4_bad_data", 64'(state_o), 0);
    csr(12'h321, 32'h0);
    chk("t4_bad_addr", 64'(state_o), 0);
    prev = cyc;
    csr(12'h320, 32'h0);
    chk("t4_mon", 64'(state_o), 1);
    chk("t4_drop_clr", 64'(drop_cnt_o), 0);
    step(5);
    chk("t4_no_snap", 64'(snap_valid_o), 0);
    csr(12'h320, 32'h5);
    chk("t4_still_mon", 64'(state_o), 1);
    c1 = cyc;
    exp_push(c1, 1'b1);
    csr(12'h320, 32'hFFFF_FFFF);
    chk("t4_drain", 64'(state_o), 2);
    chk("t4_last", 64'(snap_last_o), 1);
    step(2);
    chk("t4_one_snap", 64'(snap_valid_o), 0);
    end_detect_i = 1'b1;
    step(1);
    chk("t4_idle", 64'(state_o), 0);
    end_detect_i = 1'b0;

    // Close lands on a periodic compare.
    snap_ready_i = 1'b0;
    period_i = 16'd4;
    c0 = cyc;
    prev = c0;
    exp_push(c0 + 4, 1'b0);
    exp_push(c0 + 8, 1'b1);
    csr(12'h320, 32'h0);
    step(7);
    csr(12'h320, 32'hFFFF_FFFF);
    chk("t5_drain", 64'(state_o), 2);
    snap_ready_i = 1'b1;
    step(2);
    chk("t5_single", 64'(snap_valid_o), 0);
    chk("t5_qempty", 64'(q.size()), 0);
    end_detect_i = 1'b1;
    step(1);
    chk("t5_idle", 64'(state_o), 0);
    end_detect_i = 1'b0;

    // Reset while draining a held snapshot.
    snap_ready_i = 1'b0;
    period_i = 16'd0;
    prev = cyc;
    csr(12'h320, 32'h0);
    exp_push(cyc, 1'b1);
    csr(12'h320, 32'hFFFF_FFFF);
    chk("t6_valid", 64'(snap_valid_o), 1);
    #2 rst_h = 1'b0;
    #1;
    chk("t6_rst_valid", 64'(snap_valid_o), 0);
    chk("t6_rst_state", 64'(state_o), 0);
    chk("t6_rst_en", 64'(enable_detect_o), 0);
    q.delete();
    mseq = '0;
    step(1);
    rst_h = 1'b1;
    step(1);
    prev = cyc;
    csr(12'h320, 32'h0);
    exp_push(cyc, 1'b1);
    csr(12'h320, 32'hFFFF_FFFF);
    chk("t6_seq0", 64'(snap_seq_o), 0);
    snap_ready_i = 1'b1;
    step(2);
    end_detect_i = 1'b1;
    step(1);
    chk("t6_idle", 64'(state_o), 0);
    chk("final_qempty", 64'(q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
